tl_ul_a_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one TileLink-UL slave port (A/D channel pair, as

---
 rtl/tl_ul_a_rr_arbiter.sv | 178 +++++++++++++++++
 tb/tb_tl_ul_a_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_a_rr_arbiter.sv
// Round-robin TileLink-UL A-channel arbiter with burst lock, source prefixing and D routing.
// Optional outstanding-request cap enabled by defining TL_UL_ARB_INFLIGHT_LIMIT_EN.
module tl_ul_a_rr_arbiter #(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int SIZE_W   = 3,
  parameter int SRC_W    = 1,
  parameter int MAX_INFL = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [N_REQ-1:0]                       in_a_valid,
  output logic [N_REQ-1:0]                       in_a_ready,
  input  logic [3*N_REQ-1:0]                     in_a_opcode,
  input  logic [SIZE_W*N_REQ-1:0]                in_a_size,
  input  logic [SRC_W*N_REQ-1:0]                 in_a_source,
  input  logic [ADDR_W*N_REQ-1:0]                in_a_address,
  input  logic [(DATA_W/8)*N_REQ-1:0]            in_a_mask,
  input  logic [DATA_W*N_REQ-1:0]                in_a_data,
  output logic                                   out_a_valid,
  input  logic                                   out_a_ready,
  output logic [2:0]                             out_a_opcode,
  output logic [SIZE_W-1:0]                      out_a_size,
  output logic [SRC_W+$clog2(N_REQ)-1:0]         out_a_source,
  output logic [ADDR_W-1:0]                      out_a_address,
  output logic [DATA_W/8-1:0]                    out_a_mask,
  output logic [DATA_W-1:0]                      out_a_data,
  input  logic                                   out_d_valid,
  output logic                                   out_d_ready,
  input  logic [2:0]                             out_d_opcode,
  input  logic [SIZE_W-1:0]                      out_d_size,
  input  logic [SRC_W+$clog2(N_REQ)-1:0]         out_d_source,
  input  logic [DATA_W-1:0]                      out_d_data,
  output logic [N_REQ-1:0]                       in_d_valid,
  input  logic [N_REQ-1:0]                       in_d_ready,
  output logic [2:0]                             in_d_opcode,
  output logic [SIZE_W-1:0]                      in_d_size,
  output logic [SRC_W-1:0]                       in_d_source,
  output logic [DATA_W-1:0]                      in_d_data
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int OSRC_W  = SRC_W + IDX_W;
  localparam int BEAT_LG = $clog2(DATA_W/8);
  localparam int CNT_W   = 2**SIZE_W;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  // Beat count of a message: only multi-beat payload carriers span several beats.
  function automatic logic [CNT_W-1:0] beats_of(input logic has_data,
                                                input logic [SIZE_W-1:0] size);
    if (has_data && int'(size) > BEAT_LG) return CNT_W'(1) << (int'(size) - BEAT_LG);
    return CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] rr_idx, winner, dst;
  logic             found, locked, grant_ok, fire;
  logic [CNT_W-1:0] a_beats;

  always_comb begin
    rr_idx = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && in_a_valid[IDX_W'(ptr_q + IDX_W'(k))]) begin
        rr_idx = IDX_W'(ptr_q + IDX_W'(k));
        found  = 1'b1;
      end
    end
  end

  assign locked = (state_q == S_BURST);
  assign winner = locked ? lock_idx_q : rr_idx;

`ifdef TL_UL_ARB_INFLIGHT_LIMIT_EN
  localparam int INFL_W = $clog2(MAX_INFL+1);
  logic [INFL_W-1:0] infl_q, infl_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d, d_beats;
  logic              d_fire, d_last;

  // A burst already locked must finish even when the cap is reached.
  assign grant_ok = locked || (infl_q != INFL_W'(MAX_INFL));
`else
  assign grant_ok = 1'b1;
`endif

  assign out_a_valid   = !reset && grant_ok &&
                         (locked ? in_a_valid[lock_idx_q] : (|in_a_valid));
  assign fire          = out_a_valid && out_a_ready;
  assign in_a_ready    = fire ? (N_REQ'(1) << winner) : '0;
  assign out_a_opcode  = in_a_opcode[int'(winner)*3 +: 3];
  assign out_a_size    = in_a_size[int'(winner)*SIZE_W +: SIZE_W];
  assign out_a_source  = {winner, in_a_source[int'(winner)*SRC_W +: SRC_W]};
  assign out_a_address = in_a_address[int'(winner)*ADDR_W +: ADDR_W];
  assign out_a_mask    = in_a_mask[int'(winner)*(DATA_W/8) +: (DATA_W/8)];
  assign out_a_data    = in_a_data[int'(winner)*DATA_W +: DATA_W];
  assign a_beats       = beats_of(!out_a_opcode[2], out_a_size);

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    beat_cnt_d = beat_cnt_q;
    ptr_d      = ptr_q;
    if (fire) begin
      unique case (state_q)
        S_IDLE: begin
          if (a_beats != CNT_W'(1)) begin
            state_d    = S_BURST;
            lock_idx_d = winner;
            beat_cnt_d = a_beats - CNT_W'(1);
          end else begin
            ptr_d = winner + IDX_W'(1);
          end
        end
        S_BURST: begin
          beat_cnt_d = beat_cnt_q - CNT_W'(1);
          if (beat_cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            ptr_d   = lock_idx_q + IDX_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // D responses are steered by the index bits prefixed onto the source.
  assign dst         = out_d_source[OSRC_W-1 -: IDX_W];
  assign in_d_valid  = (!reset && out_d_valid) ? (N_REQ'(1) << dst) : '0;
  assign out_d_ready = !reset && in_d_ready[dst];
  assign in_d_opcode = out_d_opcode;
  assign in_d_size   = out_d_size;
  assign in_d_source = out_d_source[SRC_W-1:0];
  assign in_d_data   = out_d_data;

`ifdef TL_UL_ARB_INFLIGHT_LIMIT_EN
  assign d_fire  = out_d_valid && out_d_ready;
  assign d_beats = beats_of(out_d_opcode == 3'd1, out_d_size);
  assign d_last  = d_fire && ((d_cnt_q == '0) ? (d_beats == CNT_W'(1))
                                              : (d_cnt_q == CNT_W'(1)));

  always_comb begin
    d_cnt_d = d_cnt_q;
    if (d_fire) d_cnt_d = (d_cnt_q == '0) ? d_beats - CNT_W'(1) : d_cnt_q - CNT_W'(1);
    infl_d = infl_q + INFL_W'(fire && !locked) - INFL_W'(d_last);
  end
`endif

  // NOTE: non-blocking updates so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lock_idx_q <= '0;
      beat_cnt_q <= '0;
      ptr_q      <= '0;
`ifdef TL_UL_ARB_INFLIGHT_LIMIT_EN
      infl_q     <= '0;
      d_cnt_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      beat_cnt_q <= beat_cnt_d;
      ptr_q      <= ptr_d;
`ifdef TL_UL_ARB_INFLIGHT_LIMIT_EN
      infl_q     <= infl_d;
      d_cnt_q    <= d_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_tl_ul_a_rr_arbiter.sv
// Bench for tl_ul_a_rr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model; the cap scenario is built when TL_UL_ARB_INFLIGHT_LIMIT_EN is set.
module tb_tl_ul_a_rr_arbiter;
  localparam int N = 2, AW = 15, DW = 32, SW = 3, SRCW = 1, OSW = 2, MW = 4, MAXI = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]      in_a_valid = '0, in_a_ready;
  logic [3*N-1:0]    in_a_opcode = '0;
  logic [SW*N-1:0]   in_a_size = '0;
  logic [SRCW*N-1:0] in_a_source = '0;
  logic [AW*N-1:0]   in_a_address = '0;
  logic [MW*N-1:0]   in_a_mask = '0;
  logic [DW*N-1:0]   in_a_data = '0;
  logic              out_a_valid, out_a_ready = 1'b0;
  logic [2:0]        out_a_opcode;
  logic [SW-1:0]     out_a_size;
  logic [OSW-1:0]    out_a_source;
  logic [AW-1:0]     out_a_address;
  logic [MW-1:0]     out_a_mask;
  logic [DW-1:0]     out_a_data;
  logic              out_d_valid = 1'b0, out_d_ready;
  logic [2:0]        out_d_opcode = '0;
  logic [SW-1:0]     out_d_size = '0;
  logic [OSW-1:0]    out_d_source = '0;
  logic [DW-1:0]     out_d_data = '0;
  logic [N-1:0]      in_d_valid, in_d_ready = '0;
  logic [2:0]        in_d_opcode;
  logic [SW-1:0]     in_d_size;
  logic [SRCW-1:0]   in_d_source;
  logic [DW-1:0]     in_d_data;

  tl_ul_a_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .SRC_W(SRCW),
                       .MAX_INFL(MAXI)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_size(in_a_size), .in_a_source(in_a_source), .in_a_address(in_a_address),
    .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address),
    .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_data(in_d_data));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: grant pointer, locked master, beats left, outstanding count.
  int m_ptr = 0, m_lock = -1, m_left = 0, m_infl = 0, m_dleft = 0;
  int e_w, e_dst, nb, db;
  bit e_v;

  function automatic int a_beats(input int op, input int size);
    if (op != 4 && size > 2) return 1 << (size - 2);
    return 1;
  endfunction

  function automatic int d_beats(input int op, input int size);
    if (op == 1 && size > 2) return 1 << (size - 2);
    return 1;
  endfunction

  always @(negedge clock) begin
    e_dst = int'(out_d_source) >> SRCW;
    if (reset) begin
      check("rst_out_a_valid", out_a_valid, 0);
      check("rst_in_a_ready", in_a_ready, 0);
      check("rst_in_d_valid", in_d_valid, 0);
      check("rst_out_d_ready", out_d_ready, 0);
      m_ptr = 0; m_lock = -1; m_left = 0; m_infl = 0; m_dleft = 0;
    end else begin
      if (m_lock >= 0) begin
        e_w = m_lock;
        e_v = in_a_valid[m_lock];
      end else begin
        e_w = m_ptr;
        e_v = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!e_v && in_a_valid[(m_ptr + k) % N]) begin
            e_w = (m_ptr + k) % N;
            e_v = 1'b1;
          end
        end
`ifdef TL_UL_ARB_INFLIGHT_LIMIT_EN
        if (m_infl >= MAXI) e_v = 1'b0;
`endif
      end
      check("out_a_valid", out_a_valid, e_v);
      check("in_a_ready", in_a_ready, (e_v && out_a_ready) ? (1 << e_w) : 0);
      if (e_v) begin
        check("out_a_opcode", out_a_opcode, in_a_opcode[e_w*3 +: 3]);
        check("out_a_size", out_a_size, in_a_size[e_w*SW +: SW]);
        check("out_a_source", out_a_source, (e_w << SRCW) + int'(in_a_source[e_w*SRCW +: SRCW]));
        check("out_a_address", out_a_address, in_a_address[e_w*AW +: AW]);
        check("out_a_mask", out_a_mask, in_a_mask[e_w*MW +: MW]);
        check("out_a_data", out_a_data, in_a_data[e_w*DW +: DW]);
      end
      check("in_d_valid", in_d_valid, out_d_valid ? (1 << e_dst) : 0);
      check("out_d_ready", out_d_ready, in_d_ready[e_dst]);
      check("in_d_source", in_d_source, int'(out_d_source) % (1 << SRCW));
      check("in_d_opcode", in_d_opcode, out_d_opcode);
      check("in_d_size", in_d_size, out_d_size);
      check("in_d_data", in_d_data, out_d_data);

      if (e_v && out_a_ready) begin
        if (m_lock < 0) begin
          m_infl++;
          nb = a_beats(int'(in_a_opcode[e_w*3 +: 3]), int'(in_a_size[e_w*SW +: SW]));
          if (nb > 1) begin
            m_lock = e_w;
            m_left = nb - 1;
          end else begin
            m_ptr = (e_w + 1) % N;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_ptr  = (m_lock + 1) % N;
            m_lock = -1;
          end
        end
      end
      if (out_d_valid && in_d_ready[e_dst]) begin
        db = d_beats(int'(out_d_opcode), int'(out_d_size));
        if (m_dleft == 0) m_dleft = db;
        m_dleft--;
        if (m_dleft == 0) m_infl--;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic peek();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_m(input int i, input bit v, input int op, input int sz, input int src);
    in_a_valid[i]             = v;
    in_a_opcode[i*3 +: 3]     = 3'(op);
    in_a_size[i*SW +: SW]     = SW'(sz);
    in_a_source[i*SRCW +: SRCW] = SRCW'(src);
    in_a_address[i*AW +: AW]  = AW'($urandom);
    in_a_mask[i*MW +: MW]     = MW'($urandom);
    in_a_data[i*DW +: DW]     = $urandom;
  endtask

  initial begin
    // Reset with everything requesting: all handshake outputs must stay low.
    in_a_valid  = 2'b11;
    out_a_ready = 1'b1;
    out_d_valid = 1'b1;
    in_d_ready  = 2'b11;
    peek();
    check("reset_a_valid_lit", out_a_valid, 0);
    check("reset_d_valid_lit", in_d_valid, 0);
    tick();
    reset = 1'b0;
    out_d_valid = 1'b0;

`ifdef TL_UL_ARB_INFLIGHT_LIMIT_EN
    // Cap: four Gets accepted, fifth stalls until one AccessAck returns.
    set_m(0, 1, 4, 2, 0);
    set_m(1, 0, 4, 2, 0);
    for (int c = 0; c < 4; c++) begin
      peek(); check("t6_grant", in_a_ready, 2'b01); tick();
    end
    peek(); check("t6_stall", out_a_valid, 0); tick();
    out_d_valid = 1'b1; out_d_opcode = 3'd0; out_d_size = 3'd2;
    out_d_source = 2'b00; in_d_ready = 2'b01;
    peek(); check("t6_stall_ack", out_a_valid, 0); check("t6_d_ready", out_d_ready, 1);
    tick();
    out_d_valid = 1'b0;
    peek(); check("t6_resume", in_a_ready, 2'b01); tick();
    do_reset();
`endif

    // Two masters with single-beat Gets alternate.
    set_m(0, 1, 4, 2, 0);
    set_m(1, 1, 4, 2, 1);
    for (int c = 0; c < 4; c++) begin
      peek(); check("t1_source", out_a_source, (c % 2 == 1) ? 2'b11 : 2'b00); tick();
    end
    do_reset();

    // Four-beat PutFull locks out M1 until the last beat.
    set_m(0, 1, 0, 4, 0);
    set_m(1, 1, 4, 2, 1);
    for (int b = 0; b < 4; b++) begin
      peek(); check("t2_locked_ready", in_a_ready, 2'b01); tick();
      set_m(0, 1, 0, 4, 0);
    end
    set_m(0, 1, 4, 2, 0);
    peek(); check("t2_m1_next", in_a_ready, 2'b10); tick();
    do_reset();

    // Back-pressure mid-burst keeps the lock.
    set_m(0, 1, 0, 4, 0);
    set_m(1, 1, 4, 2, 1);
    peek(); check("t3_beat1", in_a_ready, 2'b01); tick();
    out_a_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      peek();
      check("t3_stall_ready", in_a_ready, 2'b00);
      check("t3_stall_owner", out_a_source[OSW-1], 0);
      tick();
    end
    out_a_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      peek(); check("t3_resume", in_a_ready, 2'b01); tick();
    end
    peek(); check("t3_m1_after", in_a_ready, 2'b10); tick();
    do_reset();

    // D routing by upper source bit concurrent with an A grant.
    set_m(1, 0, 4, 2, 0);
    set_m(0, 1, 4, 2, 0);
    out_d_valid = 1'b1; out_d_opcode = 3'd0; out_d_size = 3'd2;
    out_d_source = 2'b10; in_d_ready = 2'b10;
    peek();
    check("t4_d_valid", in_d_valid, 2'b10);
    check("t4_d_source", in_d_source, 0);
    check("t4_d_ready", out_d_ready, 1);
    check("t4_a_ready", in_a_ready, 2'b01);
    tick();
    out_d_valid = 1'b0;
    do_reset();

    // Reset mid-burst drops the lock.
    set_m(0, 1, 0, 4, 0);
    peek(); check("t5_beat1", in_a_ready, 2'b01); tick();
    peek(); check("t5_beat2", in_a_ready, 2'b01); tick();
    reset = 1'b1;
    set_m(0, 0, 0, 4, 0);
    set_m(1, 1, 4, 2, 1);
    peek(); check("t5_in_reset", out_a_valid, 0); tick();
    reset = 1'b0;
    peek(); check("t5_m1_grant", in_a_ready, 2'b10); tick();

    // Randomized traffic, the model checks every cycle.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(63) == 0);
      for (int i = 0; i < N; i++) begin
        int ops[3] = '{0, 1, 4};
        set_m(i, $urandom_range(9) < 7, ops[$urandom_range(2)], $urandom_range(4),
              $urandom_range(1));
      end
      out_a_ready  = ($urandom_range(3) != 0);
      out_d_valid  = $urandom_range(1);
`ifdef TL_UL_ARB_INFLIGHT_LIMIT_EN
      if (m_infl == 0 && m_dleft == 0) out_d_valid = 1'b0;
`endif
      out_d_opcode = 3'($urandom_range(1));
      out_d_size   = SW'($urandom_range(4));
      out_d_source = OSW'($urandom);
      out_d_data   = $urandom;
      in_d_ready   = N'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
